// File: rtl/cordic_serial_seq.sv
// rtl/cordic_serial_seq.sv - bit-serial CORDIC sequencer driving a shared 1-bit add/sub cell
module cordic_serial_seq #(
  parameter int WIDTH  = 16,
  parameter int N_ITER = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      sign_y,
  input  logic                      sign_z,
  input  logic                      fa_cout,
  output logic                      fa_op,
  output logic                      fa_cin,
  output logic                      bit_vld,
  output logic [1:0]                lane_sel,
  output logic [$clog2(WIDTH)-1:0]  bit_idx,
  output logic                      word_last,
  output logic [$clog2(N_ITER):0]   iter,
  output logic                      dir,
  output logic                      busy,
  output logic                      done
);

  localparam int BW = $clog2(WIDTH);
  localparam int IW = $clog2(N_ITER) + 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(N_ITER - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIR  = 3'd1;
  localparam logic [2:0] S_LX   = 3'd2;
  localparam logic [2:0] S_LY   = 3'd3;
  localparam logic [2:0] S_LZ   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    state;
  logic [2:0]    state_n;
  logic          mode_q;
  logic          mode_n;
  logic [BW-1:0] bit_n;
  logic [IW-1:0] iter_n;
  logic          dir_n;
  logic          in_lane;
  logic          in_lane_n;
  logic          last_bit;
  logic [1:0]    lane_n;
  logic          op_n;

  always_comb begin
    state_n  = state;
    mode_n   = mode_q;
    bit_n    = '0;
    iter_n   = iter;
    dir_n    = dir;
    in_lane  = (state == S_LX) || (state == S_LY) || (state == S_LZ);
    last_bit = in_lane && (bit_idx == BIT_LAST);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_DIR;
          mode_n  = mode;
          iter_n  = '0;
        end
      end
      S_DIR: begin
        dir_n   = mode_q ? sign_y : ~sign_z;
        state_n = S_LX;
      end
      S_LX, S_LY, S_LZ: begin
        if (!last_bit) begin
          bit_n = bit_idx + 1'b1;
        end else if (state == S_LX) begin
          state_n = S_LY;
        end else if (state == S_LY) begin
          state_n = S_LZ;
        end else if (iter < ITER_LAST) begin
          iter_n  = iter + 1'b1;
          state_n = S_DIR;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are loaded from next-state values so every port comes straight off a flop.
  always_comb begin
    in_lane_n = 1'b1;
    lane_n    = 2'd0;
    op_n      = 1'b0;
    case (state_n)
      S_LX: begin
        lane_n = 2'd0;
        op_n   = dir_n;
      end
      S_LY: begin
        lane_n = 2'd1;
        op_n   = ~dir_n;
      end
      S_LZ: begin
        lane_n = 2'd2;
        op_n   = dir_n;
      end
      default: in_lane_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      iter      <= '0;
      dir       <= 1'b0;
      bit_vld   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_idx   <= '0;
      word_last <= 1'b0;
      lane_sel  <= 2'd0;
      fa_op     <= 1'b0;
      fa_cin    <= 1'b0;
    end else begin
      state     <= state_n;
      mode_q    <= mode_n;
      iter      <= iter_n;
      dir       <= dir_n;
      bit_vld   <= in_lane_n;
      busy      <= in_lane_n || (state_n == S_DIR);
      done      <= (state_n == S_DONE);
      bit_idx   <= in_lane_n ? bit_n : '0;
      word_last <= in_lane_n && (bit_n == BIT_LAST);
      lane_sel  <= lane_n;
      fa_op     <= op_n;
      // fa_cin doubles as the inter-bit carry register; cleared at each word boundary
      fa_cin    <= (in_lane && !last_bit) ? fa_cout : 1'b0;
    end
  end

endmodule
